// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - exec-to-writeback instruction handshake bundle
interface wb_stage_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 16
);
    logic                      x_valid;
    logic [15:0]               x_pc;
    logic                      x_wen;
    logic [3:0]                x_rt;
    logic [LANE_W-1:0]         x_result;
    logic                      x_isJmp;
    logic                      x_isJz;
    logic                      x_isJnz;
    logic                      x_isJs;
    logic                      x_isJns;
    logic [LANE_W-1:0]         x_cond;
    logic [15:0]               x_target;
    logic                      x_is_vector_op;
    logic [LANES*LANE_W-1:0]   x_vresult;
    logic                      x_isHalt;
    logic                      wb_stall;

    modport master (
        output x_valid, x_pc, x_wen, x_rt, x_result,
        output x_isJmp, x_isJz, x_isJnz, x_isJs, x_isJns,
        output x_cond, x_target, x_is_vector_op, x_vresult, x_isHalt,
        input  wb_stall
    );

    modport slave (
        input  x_valid, x_pc, x_wen, x_rt, x_result,
        input  x_isJmp, x_isJz, x_isJnz, x_isJs, x_isJns,
        input  x_cond, x_target, x_is_vector_op, x_vresult, x_isHalt,
        output wb_stall
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: scalar/vector RF writes, branch redirect, halt
module wb_stage #(
    parameter int  LANES  = 4,
    parameter int  LANE_W = 16,
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    wb_stage_if.slave         xi,
    output logic              rf_wen,
    output logic [3:0]        rf_waddr,
    output logic [LANE_W-1:0] rf_wdata,
    output logic              vrf_wen,
    output logic [3:0]        vrf_waddr,
    output logic [LW-1:0]     vrf_lane,
    output logic [LANE_W-1:0] vrf_wdata,
    output logic              flush,
    output logic [15:0]       redirect_pc,
    output logic              halted
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEC_WB = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    halted_q, halted_d;
    logic                    rf_wen_q, rf_wen_d;
    logic [3:0]              rf_waddr_q, rf_waddr_d;
    logic [LANE_W-1:0]       rf_wdata_q, rf_wdata_d;
    logic                    vrf_wen_q, vrf_wen_d;
    logic [3:0]              vrf_waddr_q, vrf_waddr_d;
    logic [LW-1:0]           vrf_lane_q, vrf_lane_d;
    logic [LANE_W-1:0]       vrf_wdata_q, vrf_wdata_d;
    logic                    flush_q, flush_d;
    logic [15:0]             redirect_q, redirect_d;
    logic [LANES*LANE_W-1:0] vec_q, vec_d;

    logic                    taken;
    logic [LW-1:0]           lane_nxt;

    assign taken = xi.x_isJmp
                 | (xi.x_isJz  & (xi.x_cond == '0))
                 | (xi.x_isJnz & (xi.x_cond != '0))
                 | (xi.x_isJs  &  xi.x_cond[LANE_W-1])
                 | (xi.x_isJns & ~xi.x_cond[LANE_W-1]);

    assign lane_nxt = vrf_lane_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        rf_wen_d    = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        vrf_wen_d   = 1'b0;
        vrf_waddr_d = vrf_waddr_q;
        vrf_lane_d  = vrf_lane_q;
        vrf_wdata_d = vrf_wdata_q;
        flush_d     = 1'b0;
        redirect_d  = redirect_q;
        vec_d       = vec_q;

        case (state_q)
            S_IDLE: begin
                if (xi.x_valid) begin
                    if (xi.x_isHalt) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else if (xi.x_is_vector_op) begin
                        // Lane 0 goes out on the cycle right after accept.
                        state_d     = S_VEC_WB;
                        vec_d       = xi.x_vresult;
                        vrf_wen_d   = 1'b1;
                        vrf_waddr_d = xi.x_rt;
                        vrf_lane_d  = '0;
                        vrf_wdata_d = xi.x_vresult[LANE_W-1:0];
                    end else begin
                        if (taken) begin
                            flush_d    = 1'b1;
                            redirect_d = xi.x_target;
                        end
                        if (xi.x_wen && (xi.x_rt != 4'd0)) begin
                            rf_wen_d   = 1'b1;
                            rf_waddr_d = xi.x_rt;
                            rf_wdata_d = xi.x_result;
                        end
                    end
                end
            end
            S_VEC_WB: begin
                if (vrf_lane_q == LW'(LANES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    vrf_wen_d   = 1'b1;
                    vrf_lane_d  = lane_nxt;
                    vrf_wdata_d = vec_q[lane_nxt*LANE_W +: LANE_W];
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            halted_q    <= 1'b0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            vrf_wen_q   <= 1'b0;
            vrf_waddr_q <= '0;
            vrf_lane_q  <= '0;
            vrf_wdata_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            vrf_wen_q   <= vrf_wen_d;
            vrf_waddr_q <= vrf_waddr_d;
            vrf_lane_q  <= vrf_lane_d;
            vrf_wdata_q <= vrf_wdata_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            vec_q       <= vec_d;
        end
    end

    assign xi.wb_stall = (state_q != S_IDLE);
    assign rf_wen      = rf_wen_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign vrf_wen     = vrf_wen_q;
    assign vrf_waddr   = vrf_waddr_q;
    assign vrf_lane    = vrf_lane_q;
    assign vrf_wdata   = vrf_wdata_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed and randomized checks of wb_stage against a queue-based model
module tb_wb_stage;
    localparam int LANES  = 4;
    localparam int LANE_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if #(.LANES(LANES), .LANE_W(LANE_W)) xif();

    logic              rf_wen;
    logic [3:0]        rf_waddr;
    logic [LANE_W-1:0] rf_wdata;
    logic              vrf_wen;
    logic [3:0]        vrf_waddr;
    logic [1:0]        vrf_lane;
    logic [LANE_W-1:0] vrf_wdata;
    logic              flush;
    logic [15:0]       redirect_pc;
    logic              halted;

    wb_stage #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .xi          (xif),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .vrf_wen     (vrf_wen),
        .vrf_waddr   (vrf_waddr),
        .vrf_lane    (vrf_lane),
        .vrf_wdata   (vrf_wdata),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: what should be visible on the outputs after the most recent edge.
    typedef struct {
        int          lane;
        logic [3:0]  rt;
        logic [15:0] data;
    } vw_t;

    vw_t         vq[$];
    bit          m_halted;
    bit          after_rst;
    bit          e_rf_wen, e_vrf_wen, e_flush;
    logic [3:0]  e_rf_waddr, e_vrf_waddr;
    logic [15:0] e_rf_wdata, e_vrf_wdata, e_redir;
    int          e_vrf_lane;

    task automatic clear_inputs();
        xif.x_valid        = 1'b0;
        xif.x_pc           = '0;
        xif.x_wen          = 1'b0;
        xif.x_rt           = '0;
        xif.x_result       = '0;
        xif.x_isJmp        = 1'b0;
        xif.x_isJz         = 1'b0;
        xif.x_isJnz        = 1'b0;
        xif.x_isJs         = 1'b0;
        xif.x_isJns        = 1'b0;
        xif.x_cond         = '0;
        xif.x_target       = '0;
        xif.x_is_vector_op = 1'b0;
        xif.x_vresult      = '0;
        xif.x_isHalt       = 1'b0;
    endtask

    task automatic cycle();
        bit stall_now;
        bit acc;
        bit take;
        logic signed [15:0] sc;
        stall_now = m_halted || e_vrf_wen;
        acc = xif.x_valid && !stall_now;
        if (reset) begin
            vq.delete();
            m_halted = 0; after_rst = 1;
            e_rf_wen = 0; e_vrf_wen = 0; e_flush = 0;
            e_rf_waddr = 0; e_rf_wdata = 0; e_vrf_waddr = 0; e_vrf_wdata = 0;
            e_vrf_lane = 0; e_redir = 0;
        end else begin
            after_rst = 0;
            e_rf_wen = 0; e_vrf_wen = 0; e_flush = 0;
            if (acc) begin
                if (xif.x_isHalt) begin
                    m_halted = 1;
                end else if (xif.x_is_vector_op) begin
                    for (int i = 0; i < LANES; i++) begin
                        vw_t w;
                        w.lane = i;
                        w.rt   = xif.x_rt;
                        w.data = xif.x_vresult[i*LANE_W +: LANE_W];
                        vq.push_back(w);
                    end
                end else begin
                    sc = xif.x_cond;
                    take = xif.x_isJmp
                        || (xif.x_isJz  && sc == 0)
                        || (xif.x_isJnz && sc != 0)
                        || (xif.x_isJs  && sc < 0)
                        || (xif.x_isJns && sc >= 0);
                    if (take) begin
                        e_flush = 1; e_redir = xif.x_target;
                    end
                    if (xif.x_wen && xif.x_rt != 0) begin
                        e_rf_wen = 1; e_rf_waddr = xif.x_rt; e_rf_wdata = xif.x_result;
                    end
                end
            end
            if (vq.size() > 0) begin
                vw_t w;
                w = vq.pop_front();
                e_vrf_wen = 1; e_vrf_lane = w.lane; e_vrf_waddr = w.rt; e_vrf_wdata = w.data;
            end
        end

        @(negedge clk);
        check("wb_stall", xif.wb_stall, m_halted || e_vrf_wen);
        check("halted", halted, m_halted);
        check("rf_wen", rf_wen, e_rf_wen);
        if (e_rf_wen) begin
            check("rf_waddr", rf_waddr, e_rf_waddr);
            check("rf_wdata", rf_wdata, e_rf_wdata);
        end
        check("vrf_wen", vrf_wen, e_vrf_wen);
        if (e_vrf_wen) begin
            check("vrf_waddr", vrf_waddr, e_vrf_waddr);
            check("vrf_lane", vrf_lane, e_vrf_lane);
            check("vrf_wdata", vrf_wdata, e_vrf_wdata);
        end
        check("flush", flush, e_flush);
        if (e_flush) check("redirect_pc", redirect_pc, e_redir);
        if (after_rst) begin
            check("rst_rf_waddr", rf_waddr, 0);
            check("rst_rf_wdata", rf_wdata, 0);
            check("rst_vrf_waddr", vrf_waddr, 0);
            check("rst_vrf_lane", vrf_lane, 0);
            check("rst_vrf_wdata", vrf_wdata, 0);
            check("rst_redirect", redirect_pc, 0);
        end
    endtask

    task automatic scalar(input logic [3:0] rt, input logic [15:0] res);
        clear_inputs();
        xif.x_valid = 1; xif.x_wen = 1; xif.x_rt = rt; xif.x_result = res;
        cycle();
        clear_inputs();
    endtask

    task automatic branch(input int kind, input logic [15:0] cond, input logic [15:0] tgt);
        clear_inputs();
        xif.x_valid = 1; xif.x_cond = cond; xif.x_target = tgt;
        case (kind)
            0: xif.x_isJmp = 1;
            1: xif.x_isJz  = 1;
            2: xif.x_isJnz = 1;
            3: xif.x_isJs  = 1;
            default: xif.x_isJns = 1;
        endcase
        cycle();
        clear_inputs();
    endtask

    task automatic rand_inputs();
        int k;
        clear_inputs();
        reset              = ($urandom_range(0, 39) == 0);
        xif.x_valid        = ($urandom_range(0, 9) < 7);
        xif.x_pc           = 16'($urandom);
        xif.x_wen          = 1'($urandom_range(0, 1));
        xif.x_rt           = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        xif.x_result       = 16'($urandom);
        xif.x_target       = 16'($urandom);
        xif.x_is_vector_op = ($urandom_range(0, 5) == 0);
        xif.x_vresult      = {$urandom, $urandom};
        xif.x_isHalt       = ($urandom_range(0, 59) == 0);
        k = $urandom_range(0, 3);
        case (k)
            0: xif.x_cond = 16'h0000;
            1: xif.x_cond = 16'h8000 | 16'($urandom);
            2: xif.x_cond = 16'h7fff & 16'($urandom);
            default: xif.x_cond = 16'($urandom);
        endcase
        k = $urandom_range(0, 7);
        case (k)
            0: xif.x_isJmp = 1;
            1: xif.x_isJz  = 1;
            2: xif.x_isJnz = 1;
            3: xif.x_isJs  = 1;
            4: xif.x_isJns = 1;
            default: ;
        endcase
    endtask

    initial begin
        clear_inputs();
        m_halted = 0; e_vrf_wen = 0;
        reset = 1;
        cycle();
        cycle();
        reset = 0;

        scalar(4'd3, 16'h1234);
        cycle();
        scalar(4'd0, 16'hbeef);
        cycle();

        branch(1, 16'h0000, 16'h0040);
        branch(1, 16'h0005, 16'h0080);
        branch(3, 16'h8000, 16'h00c0);
        branch(4, 16'h8000, 16'h0100);
        branch(2, 16'h0001, 16'h0140);
        clear_inputs();
        xif.x_valid = 1; xif.x_isJmp = 1; xif.x_target = 16'h0200;
        xif.x_wen = 1; xif.x_rt = 4'd5; xif.x_result = 16'h5a5a;
        cycle();
        clear_inputs();
        cycle();

        // Vector with x_valid held through the whole stall window.
        xif.x_valid = 1; xif.x_is_vector_op = 1; xif.x_rt = 4'd2;
        xif.x_vresult = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < LANES + 1; i++) cycle();
        clear_inputs();
        cycle();
        cycle();

        // Reset while lane 1 is being written.
        xif.x_valid = 1; xif.x_is_vector_op = 1; xif.x_rt = 4'd0;
        xif.x_vresult = {16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa};
        cycle();
        clear_inputs();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        scalar(4'd7, 16'h0777);
        cycle();

        // Halt beats vector; later writes are ignored until reset.
        xif.x_valid = 1; xif.x_isHalt = 1; xif.x_is_vector_op = 1; xif.x_rt = 4'd1;
        xif.x_vresult = {$urandom, $urandom};
        cycle();
        for (int i = 0; i < 3; i++) scalar(4'd9, 16'h0999);
        reset = 1;
        cycle();
        reset = 0;
        scalar(4'd4, 16'h4040);
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
